// File: rtl/exp_engine_arbiter.sv
// Round-robin arbiter and sequencer that shares a single series-expansion
// exponential engine among N_REQ requesters. A winner's operand is latched,
// the engine is started, its ready handshake is tracked to completion, and
// the result is returned with a one-cycle done pulse to the owner.
module exp_engine_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*DW-1:0] x_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [DW-1:0]      y_out,
  output logic               busy,
  output logic               eng_start,
  output logic [DW-1:0]      eng_x,
  input  logic               eng_ready,
  input  logic [DW-1:0]      eng_y
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t            state, state_d;
  logic [PW-1:0]     owner, owner_d;
  logic [PW-1:0]     rr_ptr, rr_d;
  logic [DW-1:0]     eng_x_d, y_d;
  logic [N_REQ-1:0]  gnt_d, done_d;
  logic              start_d, busy_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;

  // Round-robin search: first active request after the last winner, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register plus all registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= PW'(N_REQ - 1);
      eng_x     <= '0;
      y_out     <= '0;
      gnt       <= '0;
      done      <= '0;
      eng_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      rr_ptr    <= rr_d;
      eng_x     <= eng_x_d;
      y_out     <= y_d;
      gnt       <= gnt_d;
      done      <= done_d;
      eng_start <= start_d;
      busy      <= busy_d;
    end
  end

  // Next-state and datapath update: grant, start, wait for busy, wait for ready.
  always_comb begin
    state_d = state;
    owner_d = owner;
    rr_d    = rr_ptr;
    eng_x_d = eng_x;
    y_d     = y_out;
    case (state)
      IDLE: begin
        // An engine still busy after an arbiter-only reset holds off new grants.
        if (win_found && eng_ready) begin
          state_d = ISSUE;
          owner_d = win_idx;
          eng_x_d = x_in[win_idx*DW +: DW];
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        // Ready still high here is the engine not yet having reacted to start.
        if (!eng_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (eng_ready) begin
          state_d = RESP;
          y_d     = eng_y;
        end
      end
      RESP: begin
        state_d = IDLE;
        rr_d    = owner;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode of the upcoming state, registered alongside it.
  always_comb begin
    gnt_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      ISSUE: begin
        gnt_d[owner_d] = 1'b1;
        start_d        = 1'b1;
      end
      RESP:    done_d[owner_d] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exp_engine_arbiter.sv
// Randomized bench for exp_engine_arbiter: a cycle-level behavioural model
// predicts grants and job windows, a scoreboard queue holds expected
// completions, and an engine model answers start pulses with y = x + 0x01B7.
module tb_exp_engine_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 16;
  localparam logic [DW-1:0] Y_OFS = 16'h01B7;

  typedef struct {
    logic [N_REQ-1:0] mask;
    logic [DW-1:0]    y;
    int               due;
  } job_t;

  typedef struct {
    int pre;
    int e;
  } eng_par_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*DW-1:0]   x_in;
  logic [N_REQ-1:0]      gnt, done;
  logic [DW-1:0]         y_out, eng_x, eng_y;
  logic                  busy, eng_start, eng_ready;
  logic                  eng_rdy_int, eng_hold;

  assign eng_ready = eng_rdy_int & ~eng_hold;

  exp_engine_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_in      (x_in),
    .gnt       (gnt),
    .done      (done),
    .y_out     (y_out),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_ready (eng_ready),
    .eng_y     (eng_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  job_t     sb_q[$];
  eng_par_t par_q[$];

  // Stimulus knobs
  int ovr_pre = 0;
  int ovr_e   = 0;
  int rearm   = 0;
  bit rand_x  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a grant happens one edge after the arbiter is seen idle
  // with ready high and some request pending; the winner is the first
  // requester after the previous winner in circular order.
  initial begin : model
    int               last_win, win, pre, e, job_end;
    bit               job_on, can_grant, busy_exp;
    logic [N_REQ-1:0] exp_g, req_s;
    logic             rdy_s;
    logic [N_REQ*DW-1:0] x_s;
    logic [DW-1:0]    xw;
    last_win  = N_REQ - 1;
    job_on    = 1'b0;
    job_end   = 0;
    can_grant = 1'b0;
    req_s     = '0;
    rdy_s     = 1'b0;
    x_s       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_gnt", gnt, '0);
        check("rst_done", done, '0);
        check("rst_busy", busy, '0);
        check("rst_start", eng_start, '0);
        check("rst_y_out", y_out, '0);
        check("rst_eng_x", eng_x, '0);
        last_win  = N_REQ - 1;
        job_on    = 1'b0;
        can_grant = 1'b0;
        sb_q.delete();
        par_q.delete();
      end else begin
        exp_g = '0;
        win   = -1;
        if (can_grant && rdy_s) begin
          for (int i = 1; i <= N_REQ; i++)
            if (win < 0 && req_s[(last_win + i) % N_REQ]) win = (last_win + i) % N_REQ;
        end
        if (win >= 0) begin
          pre = (ovr_pre != 0) ? ovr_pre : int'($urandom_range(1, 3));
          e   = (ovr_e   != 0) ? ovr_e   : int'($urandom_range(1, 5));
          xw  = x_s[win*DW +: DW];
          exp_g[win] = 1'b1;
          check("eng_x", eng_x, xw);
          sb_q.push_back('{mask: exp_g, y: xw + Y_OFS, due: cyc + pre + e + 2});
          par_q.push_back('{pre: pre, e: e});
          last_win = win;
          job_on   = 1'b1;
          job_end  = cyc + pre + e + 2;
        end
        check("gnt", gnt, exp_g);
        check("eng_start", eng_start, exp_g != '0);
        check("gnt_done_excl", (|gnt) && (|done), 1'b0);
        busy_exp = job_on && (cyc <= job_end);
        check("busy", busy, busy_exp);
        can_grant = !busy_exp;
      end
      req_s = req;
      rdy_s = eng_ready;
      x_s   = x_in;
    end
  end

  // Completion monitor: pops the scoreboard whenever done is presented.
  initial begin : monitor
    job_t          j;
    logic [DW-1:0] last_y;
    last_y = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_y = '0;
      end else if (done != '0) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", done, '0);
        end else begin
          j = sb_q.pop_front();
          check("done_mask", done, j.mask);
          check("y_out", y_out, j.y);
          check("latency", cyc, j.due);
          last_y = j.y;
        end
      end else begin
        check("y_hold", y_out, last_y);
        if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
          check("done_timeout", done, sb_q[0].mask);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Engine model: ready stays high for pre cycles after start falls, then low
  // for e cycles, then high with the result; the result bus changes afterwards.
  initial begin : engine
    eng_par_t      p;
    logic [DW-1:0] xe;
    eng_rdy_int = 1'b1;
    eng_y       = '0;
    forever begin
      @(negedge clk);
      #1;
      if (eng_start === 1'b1) begin
        if (par_q.size() > 0) p = par_q.pop_front();
        else begin
          p.pre = 1;
          p.e   = 1;
        end
        xe = eng_x;
        repeat (p.pre + 1) @(posedge clk);
        #1;
        eng_rdy_int = 1'b0;
        eng_y       = DW'($urandom);
        repeat (p.e) @(posedge clk);
        #1;
        eng_rdy_int = 1'b1;
        eng_y       = xe + Y_OFS;
        @(posedge clk);
        #1;
        eng_y = DW'($urandom);
      end
    end
  end

  // One clock of requester behaviour: drop (or keep) req on grant, maybe re-arm.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) req[k] = (rearm != 0) && ($urandom_range(0, 3) == 0);
      else if (!req[k] && rearm != 0) req[k] = ($urandom_range(0, rearm - 1) == 0);
      if (rand_x) x_in[k*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    run(2);
    rst = 1'b0;
  endtask

  initial begin : stim
    rst      = 1'b1;
    req      = '0;
    x_in     = '0;
    eng_hold = 1'b0;
    run(3);
    rst = 1'b0;

    // Single job: 6 low cycles, expected result 0x02B7, grant-to-done 10
    ovr_pre = 2;
    ovr_e   = 6;
    x_in[1*DW +: DW] = 16'h0100;
    req = 4'b0010;
    run(20);

    // Round-robin fairness with all requesters continuously re-requesting
    do_reset();
    ovr_pre = 0;
    ovr_e   = 0;
    rand_x  = 1'b1;
    rearm   = 1;
    req     = 4'b1111;
    run(60);
    rearm = 0;
    run(60);

    // Stale pointer: 2 wins, then 0 and 2 contend -> 0 first, then 2
    do_reset();
    req = 4'b0100;
    run(3);
    req = 4'b0101;
    run(40);

    // Engine not ready from reset: no grant until ready rises
    eng_hold = 1'b1;
    do_reset();
    req = 4'b0001;
    run(6);
    eng_hold = 1'b0;
    run(15);

    // Reset during WAIT_DONE, then re-grant once the engine finishes
    do_reset();
    ovr_pre = 2;
    ovr_e   = 12;
    req     = 4'b1000;
    run(6);
    ovr_pre = 0;
    ovr_e   = 0;
    rst     = 1'b1;
    req     = 4'b1000;
    run(2);
    rst = 1'b0;
    run(40);

    // Early ready ignored: 3 high cycles after start, 2 low, then high
    ovr_pre = 3;
    ovr_e   = 2;
    req     = 4'b0100;
    run(20);

    // Random traffic
    ovr_pre = 0;
    ovr_e   = 0;
    rearm   = 8;
    run(400);
    rearm = 0;
    run(80);

    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
